// File: rtl/musb_hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forward codes, stall/enable bit indices
// and the LL counter width helper.
package musb_hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_e;

    localparam int ST_IF      = 5;
    localparam int ST_ID      = 4;
    localparam int ST_EX      = 3;
    localparam int ST_EX_UNIT = 2;
    localparam int ST_MEM     = 1;
    localparam int ST_WB      = 0;

    localparam int WE_EX  = 2;
    localparam int WE_MEM = 1;
    localparam int WE_WB  = 0;

    localparam int LD_EX  = 1;
    localparam int LD_MEM = 0;

    localparam int CTL_BRANCH = 2;
    localparam int CTL_JUMP   = 1;
    localparam int CTL_MTC0   = 0;

    localparam int REQ_EX   = 2;
    localparam int REQ_DMEM = 1;
    localparam int REQ_IMEM = 0;

    localparam int EXC_IF  = 3;
    localparam int EXC_ID  = 2;
    localparam int EXC_EX  = 1;
    localparam int EXC_MEM = 0;

    function automatic int ll_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/musb_hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard; master drives pipeline state, slave is the scoreboard.
interface musb_hazard_scoreboard_if #(parameter int AW = 5, parameter int DEPTH = 4);
    import musb_hazard_scoreboard_pkg::*;
    localparam int CW = ll_cnt_w(DEPTH);

    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt;
    logic [AW-1:0] ex_gpr_wa, mem_gpr_wa, wb_gpr_wa;
    logic [2:0]    gpr_we;
    logic [1:0]    mem_to_gpr;
    logic [2:0]    id_ctrl;
    logic [2:0]    unit_req;
    logic [3:0]    exc_stall;
    logic          ll_req;
    logic [AW-1:0] ll_wa;
    logic          ll_done;
    logic [7:0]    forward_sel;
    logic [5:0]    stall;
    logic          ll_accept;
    logic [AW-1:0] ll_head_wa;
    logic [CW-1:0] ll_count;
    logic          ll_err;
    logic [31:0]   perf_stall_cnt;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_gpr_wa, mem_gpr_wa, wb_gpr_wa,
               gpr_we, mem_to_gpr, id_ctrl, unit_req, exc_stall, ll_req, ll_wa, ll_done,
        input  forward_sel, stall, ll_accept, ll_head_wa, ll_count, ll_err, perf_stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_gpr_wa, mem_gpr_wa, wb_gpr_wa,
               gpr_we, mem_to_gpr, id_ctrl, unit_req, exc_stall, ll_req, ll_wa, ll_done,
        output forward_sel, stall, ll_accept, ll_head_wa, ll_count, ll_err, perf_stall_cnt
    );
endinterface

// File: rtl/musb_ll_scoreboard.sv
// Long-latency pending-write FIFO with a per-GPR pending bit vector.
// A done on an empty FIFO is dropped and latches the sticky error flag.
module musb_ll_scoreboard #(
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [AW-1:0]            push_wa,
    input  logic                     done,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [AW-1:0]            head_wa,
    output logic                     err,
    output logic [(1<<AW)-1:0]       pend
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]       fifo_q [DEPTH];
    logic [AW-1:0]       fifo_d [DEPTH];
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;
    logic [(1<<AW)-1:0]  pend_q, pend_d;
    logic                empty, pop;

    always_comb begin
        empty   = (count_q == '0);
        pop     = done & ~empty;
        full    = (count_q == CW'(DEPTH));
        head_wa = empty ? '0 : fifo_q[rptr_q];
        fifo_d  = fifo_q;
        if (push) fifo_d[wptr_q] = push_wa;
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        err_d   = err_q | (done & empty);
        // A new issue to the register being retired keeps it pending.
        pend_d  = pend_q;
        if (pop)  pend_d[head_wa] = 1'b0;
        if (push) pend_d[push_wa] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign count = count_q;
    assign err   = err_q;
    assign pend  = pend_q;
endmodule

// File: rtl/musb_hazard_scoreboard.sv
// Pipeline hazard unit: forwarding selects, per-stage stalls and LL write tracking.
// Define MUSB_HAZARD_PERF_EN to build the saturating ID-only stall counter.
module musb_hazard_scoreboard #(
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    musb_hazard_scoreboard_if.slave hz
);
    import musb_hazard_scoreboard_pkg::*;

    logic [(1<<AW)-1:0] pend;
    logic ll_full, ll_acc;
    logic mem_ld, load_use, waw, ll_raw;
    logic st_if, st_id, st_ex, st_ex_unit, st_mem, ex_base;
    logic br_hit_rs, br_hit_rt;
    logic unused_ex_ld;

    function automatic logic [1:0] fwd_code(input logic [AW-1:0] r, input logic [AW-1:0] mwa,
                                            input logic mwe, input logic mld,
                                            input logic [AW-1:0] wwa, input logic wwe);
        if (r == '0) return FWD_NONE;
        if (mwe && !mld && mwa == r) return FWD_MEM;
        if (wwe && wwa == r) return FWD_WB;
        return FWD_NONE;
    endfunction

    always_comb begin
        mem_ld   = hz.gpr_we[WE_MEM] & hz.mem_to_gpr[LD_MEM];
        hz.forward_sel = {
            fwd_code(hz.id_rs, hz.mem_gpr_wa, hz.gpr_we[WE_MEM], hz.mem_to_gpr[LD_MEM], hz.wb_gpr_wa, hz.gpr_we[WE_WB]),
            fwd_code(hz.id_rt, hz.mem_gpr_wa, hz.gpr_we[WE_MEM], hz.mem_to_gpr[LD_MEM], hz.wb_gpr_wa, hz.gpr_we[WE_WB]),
            fwd_code(hz.ex_rs, hz.mem_gpr_wa, hz.gpr_we[WE_MEM], hz.mem_to_gpr[LD_MEM], hz.wb_gpr_wa, hz.gpr_we[WE_WB]),
            fwd_code(hz.ex_rt, hz.mem_gpr_wa, hz.gpr_we[WE_MEM], hz.mem_to_gpr[LD_MEM], hz.wb_gpr_wa, hz.gpr_we[WE_WB])
        };
        load_use = mem_ld & (hz.mem_gpr_wa != '0) &
                   ((hz.ex_rs == hz.mem_gpr_wa) | (hz.ex_rt == hz.mem_gpr_wa));
        waw      = hz.gpr_we[WE_EX] & (hz.ex_gpr_wa != '0) & pend[hz.ex_gpr_wa];
        ll_raw   = ((hz.id_rs != '0) & pend[hz.id_rs]) | ((hz.id_rt != '0) & pend[hz.id_rt]);

        st_mem     = hz.unit_req[REQ_DMEM] | hz.exc_stall[EXC_MEM];
        st_ex_unit = st_mem | load_use | hz.exc_stall[EXC_EX];
        ex_base    = st_ex_unit | hz.unit_req[REQ_EX] | waw;
        // Refused LL issue stalls EX on top of the other EX causes; accept never sees its own stall.
        ll_acc     = hz.ll_req & ~ll_full & ~ex_base;
        st_ex      = ex_base | (hz.ll_req & ll_full);
        st_if      = hz.unit_req[REQ_IMEM] | hz.exc_stall[EXC_IF];

        br_hit_rs  = (hz.id_rs != '0) & ((hz.gpr_we[WE_EX] & (hz.ex_gpr_wa == hz.id_rs)) |
                                         (mem_ld & (hz.mem_gpr_wa == hz.id_rs)));
        br_hit_rt  = (hz.id_rt != '0) & ((hz.gpr_we[WE_EX] & (hz.ex_gpr_wa == hz.id_rt)) |
                                         (mem_ld & (hz.mem_gpr_wa == hz.id_rt)));
        st_id      = st_ex
                   | (hz.id_ctrl[CTL_MTC0] & (hz.id_rt == hz.ex_gpr_wa))
                   | (hz.id_ctrl[CTL_BRANCH] & (br_hit_rs | br_hit_rt))
                   | hz.exc_stall[EXC_ID]
                   | (st_if & (hz.id_ctrl[CTL_BRANCH] | hz.id_ctrl[CTL_JUMP]))
                   | ll_raw;

        hz.stall     = {st_if, st_id, st_ex, st_ex_unit, st_mem, st_mem};
        hz.ll_accept = ll_acc;
    end

    assign unused_ex_ld = hz.mem_to_gpr[LD_EX];

    musb_ll_scoreboard #(.AW(AW), .DEPTH(DEPTH)) u_ll (
        .clk     (clk),
        .rst     (rst),
        .push    (ll_acc),
        .push_wa (hz.ll_wa),
        .done    (hz.ll_done),
        .full    (ll_full),
        .count   (hz.ll_count),
        .head_wa (hz.ll_head_wa),
        .err     (hz.ll_err),
        .pend    (pend)
    );

`ifdef MUSB_HAZARD_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (st_id && !st_ex && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign hz.perf_stall_cnt = perf_q;
`else
    assign hz.perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_musb_hazard_scoreboard.sv
// Bench for musb_hazard_scoreboard: directed scenarios plus a randomized run against a queue-based model.
module tb_musb_hazard_scoreboard;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    musb_hazard_scoreboard_if #(.AW(AW), .DEPTH(DEPTH)) hz ();
    musb_hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .hz(hz));

    // model state
    logic [4:0]  ll_q[$];
    bit          pend_m[32];
    bit          err_m;
    logic [31:0] perf_m;
    logic [7:0]  e_fwd;
    logic [5:0]  e_stall;
    logic        e_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rs = 0; hz.id_rt = 0; hz.ex_rs = 0; hz.ex_rt = 0;
        hz.ex_gpr_wa = 0; hz.mem_gpr_wa = 0; hz.wb_gpr_wa = 0;
        hz.gpr_we = 0; hz.mem_to_gpr = 0; hz.id_ctrl = 0; hz.unit_req = 0; hz.exc_stall = 0;
        hz.ll_req = 0; hz.ll_wa = 0; hz.ll_done = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        hz.ll_req = 1; hz.ll_wa = 3;
        tick();
        do_reset();
        n_cmp++; if (hz.ll_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", hz.ll_count); end
        n_cmp++; if (hz.ll_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", hz.ll_err); end
        n_cmp++; if (hz.ll_head_wa !== 5'd0) begin n_fail++; $display("FAIL reset_head: got %0d want 0", hz.ll_head_wa); end
        n_cmp++; if (hz.perf_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d want 0", hz.perf_stall_cnt); end
        n_cmp++; if (hz.stall !== 6'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 000000", hz.stall); end
        n_cmp++; if (hz.forward_sel !== 8'b0) begin n_fail++; $display("FAIL reset_fwd: got %b want 0", hz.forward_sel); end
    endtask

    task automatic test_forward();
        do_reset();
        hz.gpr_we = 3'b011; hz.mem_gpr_wa = 5; hz.wb_gpr_wa = 5; hz.ex_rs = 5;
        #1;
        n_cmp++; if (hz.forward_sel !== 8'b00_00_01_00) begin n_fail++; $display("FAIL fwd_mem: got %b want 00000100", hz.forward_sel); end
        n_cmp++; if (hz.stall !== 6'b0) begin n_fail++; $display("FAIL fwd_mem_stall: got %b want 000000", hz.stall); end
        hz.mem_to_gpr = 2'b01;
        #1;
        n_cmp++; if (hz.forward_sel !== 8'b00_00_10_00) begin n_fail++; $display("FAIL fwd_load_wb: got %b want 00001000", hz.forward_sel); end
        n_cmp++; if (hz.stall !== 6'b011100) begin n_fail++; $display("FAIL load_use_stall: got %b want 011100", hz.stall); end
        hz.mem_to_gpr = 0; hz.gpr_we = 3'b001; hz.ex_rs = 0; hz.id_rs = 5; hz.ex_rt = 5;
        #1;
        n_cmp++; if (hz.forward_sel !== 8'b10_00_00_10) begin n_fail++; $display("FAIL fwd_wb_only: got %b want 10000010", hz.forward_sel); end
        hz.gpr_we = 3'b011; hz.mem_gpr_wa = 0; hz.wb_gpr_wa = 0; hz.id_rs = 0; hz.ex_rt = 0;
        #1;
        n_cmp++; if (hz.forward_sel !== 8'b0) begin n_fail++; $display("FAIL fwd_r0: got %b want 0", hz.forward_sel); end
    endtask

    task automatic test_ll_raw();
        do_reset();
        hz.ll_req = 1; hz.ll_wa = 7;
        #1;
        n_cmp++; if (hz.ll_accept !== 1'b1) begin n_fail++; $display("FAIL raw_accept: got %b want 1", hz.ll_accept); end
        tick();
        hz.ll_req = 0; hz.id_rs = 7;
        #1;
        n_cmp++; if (hz.stall !== 6'b010000) begin n_fail++; $display("FAIL raw_stall: got %b want 010000", hz.stall); end
        n_cmp++; if (hz.ll_head_wa !== 5'd7) begin n_fail++; $display("FAIL raw_head: got %0d want 7", hz.ll_head_wa); end
        hz.ll_done = 1;
        #1;
        n_cmp++; if (hz.stall !== 6'b010000) begin n_fail++; $display("FAIL raw_done_cycle: got %b want 010000", hz.stall); end
        tick();
        hz.ll_done = 0;
        #1;
        n_cmp++; if (hz.stall !== 6'b0) begin n_fail++; $display("FAIL raw_release: got %b want 000000", hz.stall); end
        n_cmp++; if (hz.ll_count !== 3'd0) begin n_fail++; $display("FAIL raw_count: got %0d want 0", hz.ll_count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            hz.ll_req = 1; hz.ll_wa = 5'(i);
            #1;
            n_cmp++; if (hz.ll_accept !== 1'b1) begin n_fail++; $display("FAIL full_fill_acc%0d: got %b want 1", i, hz.ll_accept); end
            tick();
        end
        n_cmp++; if (hz.ll_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", hz.ll_count); end
        hz.ll_wa = 5;
        #1;
        n_cmp++; if (hz.ll_accept !== 1'b0) begin n_fail++; $display("FAIL full_refuse: got %b want 0", hz.ll_accept); end
        n_cmp++; if (hz.stall !== 6'b011000) begin n_fail++; $display("FAIL full_stall: got %b want 011000", hz.stall); end
        hz.ll_done = 1;
        #1;
        n_cmp++; if (hz.ll_accept !== 1'b0) begin n_fail++; $display("FAIL full_done_refuse: got %b want 0", hz.ll_accept); end
        tick();
        hz.ll_done = 0;
        #1;
        n_cmp++; if (hz.ll_count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d want 3", hz.ll_count); end
        n_cmp++; if (hz.ll_head_wa !== 5'd2) begin n_fail++; $display("FAIL full_pop_head: got %0d want 2", hz.ll_head_wa); end
        n_cmp++; if (hz.ll_accept !== 1'b1) begin n_fail++; $display("FAIL full_reaccept: got %b want 1", hz.ll_accept); end
        hz.ll_done = 1;
        #1;
        tick();
        hz.ll_req = 0; hz.ll_done = 0;
        #1;
        n_cmp++; if (hz.ll_count !== 3'd3) begin n_fail++; $display("FAIL full_swap_count: got %0d want 3", hz.ll_count); end
        n_cmp++; if (hz.ll_head_wa !== 5'd3) begin n_fail++; $display("FAIL full_swap_head: got %0d want 3", hz.ll_head_wa); end
    endtask

    task automatic test_err();
        do_reset();
        hz.ll_done = 1;
        tick();
        hz.ll_done = 0;
        #1;
        n_cmp++; if (hz.ll_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", hz.ll_err); end
        n_cmp++; if (hz.ll_count !== 3'd0) begin n_fail++; $display("FAIL err_count: got %0d want 0", hz.ll_count); end
        do_reset();
        n_cmp++; if (hz.ll_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", hz.ll_err); end
        hz.ll_req = 1; hz.ll_wa = 12;
        tick();
        hz.ll_req = 0;
        do_reset();
        hz.ll_done = 1;
        tick();
        hz.ll_done = 0;
        #1;
        n_cmp++; if (hz.ll_err !== 1'b1) begin n_fail++; $display("FAIL err_after_drop: got %b want 1", hz.ll_err); end
    endtask

    task automatic test_waw();
        do_reset();
        hz.ll_req = 1; hz.ll_wa = 9;
        tick();
        hz.ll_req = 0; hz.gpr_we = 3'b100; hz.ex_gpr_wa = 9;
        #1;
        n_cmp++; if (hz.stall !== 6'b011000) begin n_fail++; $display("FAIL waw_stall: got %b want 011000", hz.stall); end
        hz.ll_req = 1; hz.ll_wa = 3;
        #1;
        n_cmp++; if (hz.ll_accept !== 1'b0) begin n_fail++; $display("FAIL waw_block_acc: got %b want 0", hz.ll_accept); end
        hz.ll_req = 0;
        tick();
        n_cmp++; if (hz.stall !== 6'b011000) begin n_fail++; $display("FAIL waw_hold: got %b want 011000", hz.stall); end
        hz.ll_done = 1;
        #1;
        n_cmp++; if (hz.stall !== 6'b011000) begin n_fail++; $display("FAIL waw_done_cycle: got %b want 011000", hz.stall); end
        tick();
        hz.ll_done = 0;
        #1;
        n_cmp++; if (hz.stall !== 6'b0) begin n_fail++; $display("FAIL waw_release: got %b want 000000", hz.stall); end
    endtask

    task automatic test_perf();
        logic [31:0] want;
        do_reset();
        hz.exc_stall = 4'b0100;
        repeat (3) tick();
        hz.exc_stall = 4'b0010;
        repeat (2) tick();
        hz.exc_stall = 0;
        #1;
`ifdef MUSB_HAZARD_PERF_EN
        want = 32'd3;
`else
        want = 32'd0;
`endif
        n_cmp++; if (hz.perf_stall_cnt !== want) begin n_fail++; $display("FAIL perf_count: got %0d want %0d", hz.perf_stall_cnt, want); end
    endtask

    // Expected outputs from the stated rules, given driven inputs and the model's pending set / queue.
    task automatic model_eval();
        logic [4:0] srcs[4];
        bit mem_load, exs, refuse, ids, ifs, br;
        srcs = '{hz.id_rs, hz.id_rt, hz.ex_rs, hz.ex_rt};
        mem_load = hz.gpr_we[1] && hz.mem_to_gpr[0];
        e_fwd = 0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] f;
            f = 2'b00;
            if (srcs[k] != 0) begin
                if (hz.gpr_we[1] && !hz.mem_to_gpr[0] && hz.mem_gpr_wa == srcs[k]) f = 2'b01;
                else if (hz.gpr_we[0] && hz.wb_gpr_wa == srcs[k]) f = 2'b10;
            end
            e_fwd[7-2*k -: 2] = f;
        end
        e_stall = 0;
        e_stall[1] = hz.unit_req[1] || hz.exc_stall[0];
        e_stall[0] = e_stall[1];
        e_stall[2] = e_stall[1] || hz.exc_stall[1] ||
                     (mem_load && hz.mem_gpr_wa != 0 && (hz.ex_rs == hz.mem_gpr_wa || hz.ex_rt == hz.mem_gpr_wa));
        exs = e_stall[2] || hz.unit_req[2] || (hz.gpr_we[2] && hz.ex_gpr_wa != 0 && pend_m[hz.ex_gpr_wa]);
        refuse = hz.ll_req && (ll_q.size() == DEPTH);
        e_acc = hz.ll_req && !refuse && !exs;
        e_stall[3] = exs || refuse;
        ifs = hz.unit_req[0] || hz.exc_stall[3];
        e_stall[5] = ifs;
        br = 0;
        for (int k = 0; k < 2; k++)
            if (srcs[k] != 0 && ((hz.gpr_we[2] && hz.ex_gpr_wa == srcs[k]) || (mem_load && hz.mem_gpr_wa == srcs[k])))
                br = 1;
        ids = e_stall[3] || hz.exc_stall[2] ||
              (hz.id_ctrl[0] && hz.id_rt == hz.ex_gpr_wa) ||
              (hz.id_ctrl[2] && br) ||
              (ifs && (hz.id_ctrl[2] || hz.id_ctrl[1])) ||
              (hz.id_rs != 0 && pend_m[hz.id_rs]) || (hz.id_rt != 0 && pend_m[hz.id_rt]);
        e_stall[4] = ids;
    endtask

    task automatic model_clock();
        if (rst) begin
            ll_q.delete();
            foreach (pend_m[i]) pend_m[i] = 0;
            err_m = 0;
            perf_m = 0;
        end else begin
`ifdef MUSB_HAZARD_PERF_EN
            if (e_stall[4] && !e_stall[3] && perf_m != 32'hFFFF_FFFF) perf_m++;
`endif
            if (hz.ll_done) begin
                if (ll_q.size() == 0) err_m = 1;
                else begin
                    pend_m[ll_q[0]] = 0;
                    void'(ll_q.pop_front());
                end
            end
            if (e_acc) begin
                ll_q.push_back(hz.ll_wa);
                pend_m[hz.ll_wa] = 1;
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] e_head;
        do_reset();
        rst = 1'b1;
        model_clock();
        rst = 1'b0;
        for (int c = 0; c < 500; c++) begin
            hz.id_rs = 5'($urandom_range(0, 7));  hz.id_rt = 5'($urandom_range(0, 7));
            hz.ex_rs = 5'($urandom_range(0, 7));  hz.ex_rt = 5'($urandom_range(0, 7));
            hz.ex_gpr_wa = 5'($urandom_range(0, 7)); hz.mem_gpr_wa = 5'($urandom_range(0, 7));
            hz.wb_gpr_wa = 5'($urandom_range(0, 7));
            hz.gpr_we = 3'($urandom); hz.mem_to_gpr = 2'($urandom);
            hz.id_ctrl = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            hz.unit_req = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b0;
            hz.exc_stall = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            hz.ll_req = 1'($urandom_range(0, 1));
            hz.ll_wa = 5'($urandom_range(0, 7));
            hz.ll_done = ($urandom_range(0, 3) == 0) && (ll_q.size() != 0 || $urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 79) == 0);
            #1;
            model_eval();
            e_head = (ll_q.size() != 0) ? ll_q[0] : 5'd0;
            n_cmp++; if (hz.forward_sel !== e_fwd) begin n_fail++; $display("FAIL rnd_fwd c%0d: got %b want %b", c, hz.forward_sel, e_fwd); end
            n_cmp++; if (hz.stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, hz.stall, e_stall); end
            n_cmp++; if (hz.ll_accept !== e_acc) begin n_fail++; $display("FAIL rnd_accept c%0d: got %b want %b", c, hz.ll_accept, e_acc); end
            n_cmp++; if (hz.ll_count !== 3'(ll_q.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, hz.ll_count, ll_q.size()); end
            n_cmp++; if (hz.ll_head_wa !== e_head) begin n_fail++; $display("FAIL rnd_head c%0d: got %0d want %0d", c, hz.ll_head_wa, e_head); end
            n_cmp++; if (hz.ll_err !== err_m) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, hz.ll_err, err_m); end
            n_cmp++; if (hz.perf_stall_cnt !== perf_m) begin n_fail++; $display("FAIL rnd_perf c%0d: got %0d want %0d", c, hz.perf_stall_cnt, perf_m); end
            model_clock();
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        test_reset();
        test_forward();
        test_ll_raw();
        test_full();
        test_err();
        test_waw();
        test_perf();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "time limit");
    end
endmodule
